// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester ids and default widths for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DONE} arb_state_e;
    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_AUX  = 1'b1;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus memory pins around mem_arbiter.
// lock0/lock1 exist only when MEM_ARB_LOCK_EN is defined.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic req0, req1, rw0, rw1;
    logic [ADDR_W-1:0] addr0, addr1, mem_address;
    logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_datain, mem_dataout;
    logic gnt0, gnt1, done0, done1, mem_enable, mem_rw;
`ifdef MEM_ARB_LOCK_EN
    logic lock0, lock1;
`endif
    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_dataout,
        output gnt0, gnt1, done0, done1, rdata, mem_enable, mem_rw, mem_address, mem_datain
    );
    modport master (
`ifdef MEM_ARB_LOCK_EN
        output lock0, lock1,
`endif
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, mem_dataout,
        input  gnt0, gnt1, done0, done1, rdata, mem_enable, mem_rw, mem_address, mem_datain
    );
endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; on a tie the requester that is not last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);
    assign valid  = |req;
    assign winner = &req ? (last == REQ_AUX ? REQ_CORE : REQ_AUX) : (req[1] ? REQ_AUX : REQ_CORE);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: IDLE/GRANT/DONE round-robin arbiter sharing one data memory between two requesters.
// Define MEM_ARB_LOCK_EN to add lock0/lock1 back-to-back grant locking.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LOCK = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = ARB_IDLE;
    localparam logic [1:0] GRANT = ARB_GRANT;
    localparam logic [1:0] DONE  = ARB_DONE;

    logic [1:0] st, st_nxt;
    logic last, win, rw_q, pick_valid, pick_win, sel, load, relock;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    rr_pick2 u_pick (
        .req    ({bus.req1, bus.req0}),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick_win)
    );

`ifdef MEM_ARB_LOCK_EN
    localparam int LW = MAX_LOCK > 1 ? $clog2(MAX_LOCK) : 1;
    logic [LW-1:0] cnt;
    // A locked winner goes straight from DONE back to GRANT, at most MAX_LOCK accesses in a row
    assign relock = st == DONE && cnt < LW'(MAX_LOCK - 1) &&
                    (win == REQ_AUX ? bus.req1 && bus.lock1 : bus.req0 && bus.lock0);
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (st == DONE) cnt <= relock ? cnt + 1'b1 : '0;
`else
    assign relock = 1'b0;
`endif

    assign load = (st == IDLE && pick_valid) || relock;
    assign sel  = st == IDLE ? pick_win : win;

    always_comb
        st_nxt = st == IDLE ? (pick_valid ? GRANT : IDLE) : st == GRANT ? DONE : relock ? GRANT : IDLE;

    always_ff @(posedge clk)
        if (reset) begin
            st      <= IDLE;
            last    <= REQ_AUX;
            win     <= REQ_CORE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            st <= st_nxt;
            if (load) begin
                win     <= sel;
                rw_q    <= sel ? bus.rw1 : bus.rw0;
                addr_q  <= sel ? bus.addr1 : bus.addr0;
                wdata_q <= sel ? bus.wdata1 : bus.wdata0;
            end
            if (st == GRANT) last <= win;
            if (st == DONE && !rw_q) rdata_q <= bus.mem_dataout;
        end

    assign bus.gnt0        = st == GRANT && win == REQ_CORE;
    assign bus.gnt1        = st == GRANT && win == REQ_AUX;
    assign bus.done0       = st == DONE && win == REQ_CORE;
    assign bus.done1       = st == DONE && win == REQ_AUX;
    assign bus.mem_enable  = st == GRANT;
    assign bus.mem_rw      = st == GRANT && rw_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_datain  = wdata_q;
    // Memory read data arrives during DONE, so pass it through then and hold the captured copy after
    assign bus.rdata       = (st == DONE && !rw_q) ? bus.mem_dataout : rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter, checked every cycle against a timeline reference model plus literal spot checks.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int NC = 2048;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0, n_fail = 0;

    mem_arbiter_if #(.ADDR_W(4), .DATA_W(4)) bus ();
    mem_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_LOCK(MAX_LOCK)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Memory device seen by the arbiter: write on enabled write, dataout one cycle after enabled read
    logic [3:0] dev_mem [16] = '{4'h5, 4'hC, 4'h9, 4'h1, 4'h6, 4'hE, 4'h2, 4'hB,
                                 4'h8, 4'h3, 4'hD, 4'h0, 4'h7, 4'h4, 4'hF, 4'hA};
    always @(posedge clk)
        if (bus.mem_enable) begin
            if (bus.mem_rw) dev_mem[bus.mem_address] <= bus.mem_datain;
            else bus.mem_dataout <= dev_mem[bus.mem_address];
        end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each accepted request at edge k books a grant in cycle k+1 and a done in cycle k+2
    bit [4:0] e_ctl [NC];
    bit       e_rw  [NC];
    bit [3:0] e_addr [NC], e_din [NC], e_rd [NC], rd_val [NC];
    bit       rd_set [NC];
    bit [3:0] ref_mem [16] = '{4'h5, 4'hC, 4'h9, 4'h1, 4'h6, 4'hE, 4'h2, 4'hB,
                               4'h8, 4'h3, 4'hD, 4'h0, 4'h7, 4'h4, 4'hF, 4'hA};
    int cyc = 0, free_at = 0, lock_edge = -1, run = 0;
    bit mlast = 1'b1, lock_w = 1'b0;
    bit [3:0] rd_hold = 4'h0;

    always @(posedge clk) begin : model
        int k;
        bit acc, w, wr, lk;
        bit [3:0] a, d;
        k = cyc;
        acc = 1'b0;
        w = 1'b0;
        if (k + 3 < NC) begin
            if (reset) begin
                for (int j = k + 1; j <= k + 3; j++) begin
                    e_ctl[j] = '0;
                    rd_set[j] = 1'b0;
                end
                free_at = k + 1;
                lock_edge = -1;
                run = 0;
                mlast = 1'b1;
                rd_hold = 4'h0;
            end else begin
`ifdef MEM_ARB_LOCK_EN
                lk = lock_w ? (bus.req1 && bus.lock1) : (bus.req0 && bus.lock0);
`else
                lk = 1'b0;
`endif
                if (k == lock_edge && lk && run < MAX_LOCK - 1) begin
                    acc = 1'b1;
                    w = lock_w;
                    run++;
                end else if (k >= free_at && (bus.req0 || bus.req1)) begin
                    acc = 1'b1;
                    w = (bus.req0 && bus.req1) ? !mlast : bus.req1;
                    run = 0;
                end
                if (acc) begin
                    wr = w ? bus.rw1 : bus.rw0;
                    a = w ? bus.addr1 : bus.addr0;
                    d = w ? bus.wdata1 : bus.wdata0;
                    mlast = w;
                    e_ctl[k + 1] = {!w, w, 2'b00, 1'b1};
                    e_ctl[k + 2] = {2'b00, !w, w, 1'b0};
                    e_rw[k + 1] = wr;
                    e_addr[k + 1] = a;
                    e_din[k + 1] = d;
                    if (wr) ref_mem[a] = d;
                    else begin
                        rd_set[k + 2] = 1'b1;
                        rd_val[k + 2] = ref_mem[a];
                    end
                    free_at = k + 3;
                    lock_edge = k + 2;
                    lock_w = w;
                end
            end
            e_rd[k + 1] = rd_set[k + 1] ? rd_val[k + 1] : rd_hold;
            if (rd_set[k + 1]) rd_hold = rd_val[k + 1];
        end
        cyc = k + 1;
    end

    int g_id[$], g_cyc[$], d_cyc[$];

    always @(negedge clk)
        if (cyc >= 1 && cyc < NC) begin
            check("ctl", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_enable}, e_ctl[cyc]);
            if (e_ctl[cyc][0])
                check("mem_bus", {bus.mem_rw, bus.mem_address, bus.mem_datain}, {e_rw[cyc], e_addr[cyc], e_din[cyc]});
            check("rdata", bus.rdata, e_rd[cyc]);
            if (bus.gnt0) begin g_id.push_back(0); g_cyc.push_back(cyc); end
            if (bus.gnt1) begin g_id.push_back(1); g_cyc.push_back(cyc); end
            if (bus.done0 || bus.done1) d_cyc.push_back(cyc);
        end

    function automatic int qat(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    function automatic logic [17:0] outs();
        return {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_enable, bus.mem_rw,
                bus.mem_address, bus.mem_datain, bus.rdata};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        g_id.delete();
        g_cyc.delete();
        d_cyc.delete();
    endtask

    task automatic drive(input bit id, input bit r, input bit w, input logic [3:0] a, input logic [3:0] d);
        if (id) begin bus.req1 = r; bus.rw1 = w; bus.addr1 = a; bus.wdata1 = d; end
        else begin bus.req0 = r; bus.rw0 = w; bus.addr0 = a; bus.wdata0 = d; end
    endtask

    task automatic access(input bit id, input bit w, input logic [3:0] a, input logic [3:0] d,
                          output int lg, output int ld, output logic [3:0] rd);
        drive(id, 1'b1, w, a, d);
        lg = -1;
        ld = -1;
        rd = 'x;
        for (int i = 1; i <= 8 && ld < 0; i++) begin
            @(negedge clk);
            if ((id ? bus.gnt1 : bus.gnt0) && lg < 0) lg = i;
            if (id ? bus.done1 : bus.done0) begin ld = i; rd = bus.rdata; end
        end
        drive(id, 1'b0, w, a, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lg, ld;
        bit s0, s1, seen;
        logic [3:0] rd;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
`ifdef MEM_ARB_LOCK_EN
        bus.lock0 = 1'b0;
        bus.lock1 = 1'b0;
`endif
        tick(2);
        check("reset_vals", outs(), 18'h0);
        reset = 1'b0;
        tick(1);

        // single write then read of address 3
        access(0, 1, 4'h3, 4'hA, lg, ld, rd);
        check("wr_gnt_lat", lg, 1);
        check("wr_done_lat", ld, 2);
        tick(1);
        access(1, 0, 4'h3, 4'h0, lg, ld, rd);
        check("rd_gnt_lat", lg, 1);
        check("rd_done_lat", ld, 2);
        check("rd_data", rd, 4'hA);

        // simultaneous requests right after reset
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        clear_logs();
        drive(0, 1, 0, 4'h3, 4'h0);
        drive(1, 1, 0, 4'h7, 4'h0);
        s0 = 0;
        s1 = 0;
        for (int i = 0; i < 12 && !(s0 && s1); i++) begin
            tick(1);
            if (bus.done0) begin s0 = 1; bus.req0 = 1'b0; end
            if (bus.done1) begin s1 = 1; bus.req1 = 1'b0; end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        check("sim_both_done", {s0, s1}, 2'b11);
        tick(2);
        check("sim_first", qat(g_id, 0), 0);
        check("sim_second", qat(g_id, 1), 1);
        check("sim_done_gap", qat(d_cyc, 1) - qat(d_cyc, 0), 3);

        // continuous contention for 12 cycles
        clear_logs();
        drive(0, 1, 0, 4'h1, 4'h0);
        drive(1, 1, 0, 4'h2, 4'h0);
        tick(12);
        drive(0, 0, 0, 4'h1, 4'h0);
        drive(1, 0, 0, 4'h2, 4'h0);
        tick(4);
        check("cont_count", g_id.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("cont_order", qat(g_id, i), i % 2);
            if (i > 0) check("cont_gap", qat(g_cyc, i) - qat(g_cyc, i - 1), 3);
        end

        // early request drop with payload changed after the latch
        drive(0, 1, 1, 4'h5, 4'h7);
        tick(1);
        check("drop_gnt", bus.gnt0, 1);
        drive(0, 0, 1, 4'hF, 4'h0);
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick(1);
            if (bus.done0) seen = 1;
        end
        check("drop_done", seen, 1);
        tick(1);
        check("drop_mem", dev_mem[5], 4'h7);
        check("drop_mem_other", dev_mem[15], 4'hA);

        // reset during GRANT abandons the access
        drive(1, 1, 0, 4'h5, 4'h0);
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick(1);
            if (bus.gnt1) seen = 1;
        end
        check("rst_gnt_seen", seen, 1);
        reset = 1'b1;
        bus.req1 = 1'b0;
        tick(1);
        check("rst_outputs", outs(), 18'h0);
        reset = 1'b0;
        seen = 0;
        repeat (3) begin
            tick(1);
            if (bus.done0 || bus.done1) seen = 1;
        end
        check("rst_no_done", seen, 0);
        access(1, 0, 4'h5, 4'h0, lg, ld, rd);
        check("post_rst_lat", lg, 1);
        check("post_rst_rd", rd, 4'h7);

`ifdef MEM_ARB_LOCK_EN
        // requester 0 locks for MAX_LOCK accesses while requester 1 waits
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        clear_logs();
        drive(0, 1, 0, 4'h1, 4'h0);
        drive(1, 1, 0, 4'h2, 4'h0);
        bus.lock0 = 1'b1;
        tick(11);
        drive(0, 0, 0, 4'h1, 4'h0);
        drive(1, 0, 0, 4'h2, 4'h0);
        bus.lock0 = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) check("lock_order", qat(g_id, i), i == 4 ? 1 : 0);
        for (int i = 1; i < 5; i++) check("lock_gap", qat(g_cyc, i) - qat(g_cyc, i - 1), i == 4 ? 3 : 2);
`endif

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
